// File: rtl/ysyx_22050058_ifu_pkg.sv
// ysyx_22050058_ifu_pkg: shared fetch constants, bus widths, FSM encodings and buffer entry type
package ysyx_22050058_ifu_pkg;
    localparam int InstAddrBus = 64;
    localparam int InstBus = 32;
    localparam logic [InstAddrBus-1:0] RstVector = 64'h0000_0000_8000_0000;
    localparam logic [InstBus-1:0] ZeroWord = 32'h0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0] inst;
    } ifu_ent_t;
endpackage

// File: rtl/ysyx_22050058_ifu_fifo.sv
// ysyx_22050058_ifu_fifo: DEPTH-entry FIFO (push/pop/flush in, dout/count/full/empty out), flush wins
module ysyx_22050058_ifu_fifo #(
    parameter int W = 96,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
endmodule

// File: rtl/ysyx_22050058_ifu.sv
// ysyx_22050058_ifu: fetch FSM (one outstanding imem request, redirect/discard) feeding a PC+inst FIFO to ID
module ysyx_22050058_ifu
    import ysyx_22050058_ifu_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RST_VECTOR = RstVector,
    parameter int BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ifu_redirect_i,
    input  logic [InstAddrBus-1:0] ifu_redirect_pc_i,
    input  logic                   ifu_stall_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
    output logic                   ifu_valid_o,
    output logic [InstAddrBus-1:0] ifu_pc_o,
    output logic [InstBus-1:0]     ifu_inst_o,
    output logic                   ifu_stall_req_o
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    logic [1:0] state, state_n;
    logic [InstAddrBus-1:0] fetch_pc, req_pc;
    logic [CW-1:0] count;
    logic gnt_ok, push, pop, full, empty;
    ifu_ent_t din, head;
    assign imem_req_o = !rst && state == ST_REQ && count < CW'(BUF_DEPTH);
    assign imem_addr_o = fetch_pc;
    assign gnt_ok = imem_req_o && imem_gnt_i;
    assign push = state == ST_WAIT && imem_rvalid_i && !ifu_redirect_i && !full;
    assign pop = !empty && !ifu_stall_i && !ifu_redirect_i;
    assign din = '{pc: req_pc, inst: imem_rdata_i};
    assign ifu_valid_o = !empty;
    assign ifu_pc_o = empty ? '0 : head.pc;
    assign ifu_inst_o = empty ? ZeroWord : head.inst;
    assign ifu_stall_req_o = empty && state != ST_IDLE;
    // a response arriving in DISCARD retires the stale request even if a new redirect comes with it
    assign state_n = state == ST_IDLE ? ST_REQ :
                     state == ST_REQ ? (gnt_ok ? (ifu_redirect_i ? ST_DISCARD : ST_WAIT) : ST_REQ) :
                     imem_rvalid_i ? ST_REQ :
                     (state == ST_DISCARD || ifu_redirect_i) ? ST_DISCARD : ST_WAIT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            fetch_pc <= RST_VECTOR;
            req_pc <= RST_VECTOR;
        end else begin
            state <= state_n;
            fetch_pc <= ifu_redirect_i ? (ifu_redirect_pc_i & ~64'h3) : gnt_ok ? fetch_pc + 64'd4 : fetch_pc;
            if (gnt_ok) req_pc <= fetch_pc;
        end
    end
    ysyx_22050058_ifu_fifo #(.W($bits(ifu_ent_t)), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(ifu_redirect_i),
        .din(din),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_ysyx_22050058_ifu.sv
// tb_ysyx_22050058_ifu: randomized and directed checks of the IFU against a queue-based fetch model
module tb_ysyx_22050058_ifu;
    localparam int DEPTH = 4;
    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    logic clk = 0, rst = 1, redirect = 0, stall = 0, gnt = 0, rvalid = 0;
    logic [63:0] redirect_pc = '0;
    logic [31:0] rdata = '0;
    logic req, valid, stall_req;
    logic [63:0] addr, pc;
    logic [31:0] inst;
    int n_chk = 0, n_fail = 0;
    bit started = 0, outst = 0, stale = 0;
    logic [63:0] npc = RV, rpc_q = '0;
    int wait_cnt = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    ysyx_22050058_ifu #(.RST_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .ifu_redirect_i(redirect),
        .ifu_redirect_pc_i(redirect_pc),
        .ifu_stall_i(stall),
        .imem_req_o(req),
        .imem_addr_o(addr),
        .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata),
        .ifu_valid_o(valid),
        .ifu_pc_o(pc),
        .ifu_inst_o(inst),
        .ifu_stall_req_o(stall_req)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    function automatic bit exp_req();
        return started && !outst && q.size() < DEPTH;
    endfunction

    task automatic cycle(input bit r, input logic [63:0] rpc, input bit st, input bit g, input int dly, input bit rs);
        bit er, gr, rv, pop;
        @(negedge clk);
        er = exp_req();
        check("req", req, er);
        check("addr", addr, npc);
        check("valid", valid, q.size() > 0);
        check("pc", pc, q.size() > 0 ? q[0].pc : 64'h0);
        check("inst", inst, q.size() > 0 ? q[0].inst : 32'h0);
        check("stall_req", stall_req, started && q.size() == 0);
        rv = outst && wait_cnt == 0;
        rst = rs;
        redirect = r;
        redirect_pc = rpc;
        stall = st;
        gnt = g && er;
        rvalid = rv;
        rdata = rv ? mem_f(rpc_q) : $urandom;
        @(posedge clk);
        if (rs) begin
            started = 0;
            outst = 0;
            stale = 0;
            q.delete();
            npc = RV;
        end else begin
            gr = er && g;
            pop = q.size() > 0 && !st && !r;
            if (pop) void'(q.pop_front());
            if (rv) begin
                if (!stale && !r) q.push_back('{rpc_q, mem_f(rpc_q)});
                outst = 0;
                stale = 0;
            end else if (outst) begin
                if (wait_cnt > 0) wait_cnt--;
                if (r) stale = 1;
            end
            if (gr) begin
                outst = 1;
                stale = r;
                rpc_q = npc;
                wait_cnt = dly;
            end
            npc = r ? (rpc & ~64'h3) : gr ? npc + 64'd4 : npc;
            if (r) q.delete();
            started = 1;
        end
    endtask

    task automatic wait_req(input string tag);
        int i;
        for (i = 0; i < 20 && !exp_req(); i++) cycle(0, '0, 0, 0, 0, 0);
        check(tag, i < 20, 1);
    endtask

    initial begin
        int i;
        repeat (2) @(posedge clk);
        // reset release, zero-wait memory
        cycle(0, '0, 0, 1, 0, 0);
        #1 check("first_req", req, 1);
        check("first_addr", addr, 64'h8000_0000);
        cycle(0, '0, 0, 1, 0, 0);
        #1 check("no_valid_yet", valid, 0);
        check("second_addr", addr, 64'h8000_0004);
        cycle(0, '0, 0, 1, 0, 0);
        #1 check("valid_rise", valid, 1);
        check("valid_pc", pc, 64'h8000_0000);
        // stall fills the buffer, release drains in order
        repeat (10) cycle(0, '0, 1, 1, 0, 0);
        #1 check("full_req", req, 0);
        check("full_pc", pc, 64'h8000_0000);
        repeat (12) cycle(0, '0, 0, 1, 0, 0);
        // redirect while waiting on a slow response
        wait_req("wait_req_a");
        cycle(0, '0, 0, 1, 3, 0);
        cycle(1, 64'h8000_0102, 0, 1, 0, 0);
        for (i = 0; i < 10 && outst; i++) cycle(0, '0, 0, 0, 0, 0);
        check("stale_drained", i < 10, 1);
        #1 check("redir_addr", addr, 64'h8000_0100);
        check("redir_empty", valid, 0);
        repeat (4) cycle(0, '0, 0, 1, 0, 0);
        // redirect coinciding with rvalid
        wait_req("wait_req_b");
        cycle(0, '0, 1, 1, 0, 0);
        cycle(1, 64'h8000_0200, 0, 1, 0, 0);
        #1 check("redir_rv_empty", valid, 0);
        check("redir_rv_addr", addr, 64'h8000_0200);
        // address wrap
        wait_req("wait_req_c");
        cycle(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
        #1 check("wrap_addr", addr, 64'h0);
        repeat (4) cycle(0, '0, 0, 1, 0, 0);
        // reset mid-WAIT with two entries buffered
        for (i = 0; i < 30 && !(q.size() == 2 && outst); i++) cycle(0, '0, 1, 1, 2, 0);
        check("mid_wait_reached", i < 30, 1);
        cycle(0, '0, 1, 1, 0, 1);
        #1 check("rst_valid", valid, 0);
        check("rst_req", req, 0);
        check("rst_addr", addr, RV);
        check("rst_pc", pc, 64'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_stall_req", stall_req, 0);
        repeat (6) cycle(0, '0, 0, 1, 0, 0);
        // randomized traffic
        repeat (600)
            cycle($urandom_range(0, 15) == 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 99) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
